// File: rtl/issue_queue_pkg.sv
// ---------------------------------------------------------------------------
// issue_queue_pkg
// Shared CPU definitions used by the instruction issue queue: RV32 opcode
// constants, the canonical NOP encoding, the queue entry layout and small
// opcode classification helpers.
// Ports: none (package).
// ---------------------------------------------------------------------------
package issue_queue_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } iq_entry_t;

  // Formats that produce a destination register value.
  function automatic logic writes_rd(input logic [6:0] opc);
    return (opc == OP) || (opc == OP_IMM) || (opc == LOAD) || (opc == LUI) ||
           (opc == AUIPC) || (opc == JAL) || (opc == JALR);
  endfunction

  // Formats whose rs1 field is a real source operand.
  function automatic logic reads_rs1(input logic [6:0] opc);
    return (opc == OP) || (opc == OP_IMM) || (opc == LOAD) || (opc == STORE) ||
           (opc == BRANCH) || (opc == JALR);
  endfunction

  // Formats whose rs2 field is a real source operand.
  function automatic logic reads_rs2(input logic [6:0] opc);
    return (opc == OP) || (opc == STORE) || (opc == BRANCH);
  endfunction

  function automatic logic is_mem(input logic [6:0] opc);
    return (opc == LOAD) || (opc == STORE);
  endfunction

  function automatic logic is_ctrl(input logic [6:0] opc);
    return (opc == BRANCH) || (opc == JAL) || (opc == JALR);
  endfunction

endpackage

// File: rtl/issue_queue_pair_check.sv
// ---------------------------------------------------------------------------
// pair_check
// Purely combinational check deciding whether two adjacent queue entries may
// be issued together in the same cycle.
// Ports:
//   older   in  32  instruction at the queue head (goes to decode slot 1)
//   younger in  32  instruction behind it (would go to decode slot 2)
//   legal   out 1   1 = the pair may dual-issue
// ---------------------------------------------------------------------------
module pair_check
  import issue_queue_pkg::*;
(
  input  logic [31:0] older,
  input  logic [31:0] younger,
  output logic        legal
);

  logic [6:0] opc_old;
  logic [6:0] opc_young;
  logic [4:0] rd_old;
  logic [4:0] rs1_young;
  logic [4:0] rs2_young;
  logic       raw_hazard;
  logic       ctrl_old;
  logic       both_mem;
  logic       unused_bits;

  assign opc_old   = older[6:0];
  assign rd_old    = older[11:7];
  assign opc_young = younger[6:0];
  assign rs1_young = younger[19:15];
  assign rs2_young = younger[24:20];

  // Writes to x0 are discarded, so they can never create a dependency.
  assign raw_hazard = writes_rd(opc_old) && (rd_old != 5'd0) &&
                      ((reads_rs1(opc_young) && (rs1_young == rd_old)) ||
                       (reads_rs2(opc_young) && (rs2_young == rd_old)));

  // Anything after a control transfer may be on the wrong path.
  assign ctrl_old = is_ctrl(opc_old);

  // Only one data memory port exists.
  assign both_mem = is_mem(opc_old) && is_mem(opc_young);

  assign legal = !(raw_hazard || ctrl_old || both_mem);

  assign unused_bits = ^{older[31:12], younger[31:25], younger[14:7]};

endmodule

// File: rtl/issue_queue.sv
// ---------------------------------------------------------------------------
// issue_queue
// Decouples a two-wide fetch stage from two decode pipelines. Fetched
// instructions are buffered in a circular queue; each cycle up to two head
// entries are selected (subject to pair legality) and registered into the
// decode slots.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   InstrF1/2, PCF1/2        fetched instructions and PCs, F1 is older
//   ValidF1/2                fetch slot valid
//   ReadyF                   queue has room for two more entries
//   StallD                   decode holds: outputs frozen, no dequeue
//   FlushD                   discard queue and decode-slot contents
//   InstrD1/2, PCD1/2        registered issue group, slot 1 is older
//   ValidD1/2                decode slot holds a real instruction
// ---------------------------------------------------------------------------
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrF1,
  input  logic [31:0] InstrF2,
  input  logic [31:0] PCF1,
  input  logic [31:0] PCF2,
  input  logic        ValidF1,
  input  logic        ValidF2,
  output logic        ReadyF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic [31:0] InstrD1,
  output logic [31:0] InstrD2,
  output logic [31:0] PCD1,
  output logic [31:0] PCD2,
  output logic        ValidD1,
  output logic        ValidD2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  iq_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               enq_ok;
  logic [1:0]         enq_num;
  logic [1:0]         deq_num;
  iq_entry_t          head;
  iq_entry_t          second;
  logic               pair_legal;

  // Room is judged on the occupancy at the start of the cycle, so fetch never
  // relies on entries that are only leaving this cycle.
  assign ReadyF  = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
  assign enq_ok  = ReadyF && !FlushD;
  assign enq_num = enq_ok ? ({1'b0, ValidF1} + {1'b0, ValidF2}) : 2'd0;

  assign head   = mem[rd_ptr];
  assign second = mem[rd_ptr + PTR_W'(1)];

  pair_check u_pair_check (
    .older   (head.instr),
    .younger (second.instr),
    .legal   (pair_legal)
  );

  // Issue width for this cycle; a lone head entry always goes to slot 1.
  always_comb begin
    deq_num = 2'd0;
    if (!StallD && !FlushD) begin
      if ((count >= CNT_W'(2)) && pair_legal) begin
        deq_num = 2'd2;
      end else if (count >= CNT_W'(1)) begin
        deq_num = 2'd1;
      end
    end
  end

  // Storage is not reset; entries beyond count are never looked at. A lone
  // F2 takes the slot F1 would have used so the queue stays dense.
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      if (ValidF1) begin
        mem[wr_ptr] <= '{instr: InstrF1, pc: PCF1};
      end
      if (ValidF2) begin
        mem[ValidF1 ? wr_ptr + PTR_W'(1) : wr_ptr] <= '{instr: InstrF2, pc: PCF2};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (FlushD) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(deq_num);
      wr_ptr <= wr_ptr + PTR_W'(enq_num);
      count  <= count + CNT_W'(enq_num) - CNT_W'(deq_num);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD1 <= NOP;
      InstrD2 <= NOP;
      PCD1    <= '0;
      PCD2    <= '0;
      ValidD1 <= 1'b0;
      ValidD2 <= 1'b0;
    end else if (FlushD) begin
      InstrD1 <= NOP;
      InstrD2 <= NOP;
      PCD1    <= '0;
      PCD2    <= '0;
      ValidD1 <= 1'b0;
      ValidD2 <= 1'b0;
    end else if (!StallD) begin
      InstrD1 <= (deq_num != 2'd0) ? head.instr : NOP;
      PCD1    <= (deq_num != 2'd0) ? head.pc : 32'd0;
      ValidD1 <= (deq_num != 2'd0);
      InstrD2 <= (deq_num == 2'd2) ? second.instr : NOP;
      PCD2    <= (deq_num == 2'd2) ? second.pc : 32'd0;
      ValidD2 <= (deq_num == 2'd2);
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_issue_queue
// Directed bench for issue_queue with a reference queue of pending entries.
// Entries are pushed when fetch stimulus is accepted and popped into the
// expected decode slots when the model selects them for issue.
// ---------------------------------------------------------------------------
module tb_issue_queue;

  localparam int DEPTH = 8;
  localparam logic [31:0] NOP_I = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [31:0] instr_f1, instr_f2, pc_f1, pc_f2;
  logic        valid_f1, valid_f2;
  logic        ready_f;
  logic        stall_d, flush_d;
  logic [31:0] instr_d1, instr_d2, pc_d1, pc_d2;
  logic        valid_d1, valid_d2;

  ent_t        mq[$];
  logic [31:0] e1_instr, e1_pc, e2_instr, e2_pc;
  logic        e1_valid, e2_valid;
  int          tests;
  int          fails;

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .InstrF1 (instr_f1),
    .InstrF2 (instr_f2),
    .PCF1    (pc_f1),
    .PCF2    (pc_f2),
    .ValidF1 (valid_f1),
    .ValidF2 (valid_f2),
    .ReadyF  (ready_f),
    .StallD  (stall_d),
    .FlushD  (flush_d),
    .InstrD1 (instr_d1),
    .InstrD2 (instr_d2),
    .PCD1    (pc_d1),
    .PCD2    (pc_d2),
    .ValidD1 (valid_d1),
    .ValidD2 (valid_d2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'd0, rd, 7'h13};
  endfunction

  // Independent reading of the dual-issue rules.
  function automatic bit bench_legal(input logic [31:0] a, input logic [31:0] b);
    logic [6:0] oa;
    logic [6:0] ob;
    bit a_wr, b_r1, b_r2;
    oa = a[6:0];
    ob = b[6:0];
    if (oa == 7'h63 || oa == 7'h6f || oa == 7'h67) return 1'b0;
    if ((oa == 7'h03 || oa == 7'h23) && (ob == 7'h03 || ob == 7'h23)) return 1'b0;
    a_wr = (oa inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6f, 7'h67}) && (a[11:7] != 5'd0);
    b_r1 = ob inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    b_r2 = ob inside {7'h33, 7'h23, 7'h63};
    if (a_wr && ((b_r1 && b[19:15] == a[11:7]) || (b_r2 && b[24:20] == a[11:7]))) return 1'b0;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v1, input logic [31:0] i1, input logic [31:0] p1,
                               input logic v2, input logic [31:0] i2, input logic [31:0] p2,
                               input logic stall, input logic flush);
    valid_f1 = v1; instr_f1 = i1; pc_f1 = p1;
    valid_f2 = v2; instr_f2 = i2; pc_f2 = p2;
    stall_d  = stall;
    flush_d  = flush;
  endtask

  task automatic clear_expected();
    e1_instr = NOP_I; e1_pc = 32'd0; e1_valid = 1'b0;
    e2_instr = NOP_I; e2_pc = 32'd0; e2_valid = 1'b0;
  endtask

  // One clock: predict ReadyF and the next issue group, advance, compare.
  task automatic step_cycle();
    bit   rdy;
    int   n;
    ent_t e;
    rdy = (DEPTH - mq.size()) >= 2;
    checkOutput("ReadyF", {31'd0, ready_f}, {31'd0, rdy});
    if (flush_d) begin
      mq.delete();
      clear_expected();
    end else begin
      if (!stall_d) begin
        n = 0;
        if (mq.size() >= 2 && bench_legal(mq[0].instr, mq[1].instr)) n = 2;
        else if (mq.size() >= 1) n = 1;
        clear_expected();
        if (n >= 1) begin
          e = mq.pop_front();
          e1_instr = e.instr; e1_pc = e.pc; e1_valid = 1'b1;
        end
        if (n == 2) begin
          e = mq.pop_front();
          e2_instr = e.instr; e2_pc = e.pc; e2_valid = 1'b1;
        end
      end
      if (rdy) begin
        if (valid_f1) mq.push_back('{instr: instr_f1, pc: pc_f1});
        if (valid_f2) mq.push_back('{instr: instr_f2, pc: pc_f2});
      end
    end
    @(posedge clk);
    #1;
    checkOutput("ValidD1", {31'd0, valid_d1}, {31'd0, e1_valid});
    checkOutput("ValidD2", {31'd0, valid_d2}, {31'd0, e2_valid});
    checkOutput("InstrD1", instr_d1, e1_instr);
    checkOutput("InstrD2", instr_d2, e2_instr);
    checkOutput("PCD1", pc_d1, e1_pc);
    checkOutput("PCD2", pc_d2, e2_pc);
  endtask

  // Present a fetch pair and hold it until the queue accepts it.
  task automatic feed(input logic v1, input logic [31:0] i1, input logic [31:0] p1,
                      input logic v2, input logic [31:0] i2, input logic [31:0] p2,
                      input logic stall);
    bit r;
    applyStimulus(v1, i1, p1, v2, i2, p2, stall, 1'b0);
    for (int k = 0; k < 16; k++) begin
      r = (DEPTH - mq.size()) >= 2;
      step_cycle();
      if (r) break;
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, stall, 1'b0);
  endtask

  task automatic drain(input int cycles);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (cycles) step_cycle();
  endtask

  task automatic fill_addi(input int pairs, input logic [31:0] base_pc, input logic stall);
    for (int k = 0; k < pairs; k++) begin
      feed(1'b1, mk_addi(5'(2 * k + 1), 12'(k)), base_pc + 32'(8 * k),
           1'b1, mk_addi(5'(2 * k + 2), 12'(k + 1)), base_pc + 32'(8 * k + 4), stall);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clear_expected();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ValidD1", {31'd0, valid_d1}, 32'd0);
    checkOutput("rst_ValidD2", {31'd0, valid_d2}, 32'd0);
    checkOutput("rst_InstrD1", instr_d1, NOP_I);
    checkOutput("rst_InstrD2", instr_d2, NOP_I);
    checkOutput("rst_PCD1", pc_d1, 32'd0);
    checkOutput("rst_ReadyF", {31'd0, ready_f}, 32'd1);
    rst = 1'b0;

    // Two independent addi instructions dual-issue two cycles after fetch.
    feed(1'b1, 32'h00100093, 32'h100, 1'b1, 32'h00200113, 32'h104, 1'b0);
    checkOutput("lat_ValidD1_early", {31'd0, valid_d1}, 32'd0);
    step_cycle();
    checkOutput("dual_InstrD1", instr_d1, 32'h00100093);
    checkOutput("dual_InstrD2", instr_d2, 32'h00200113);
    checkOutput("dual_ValidD2", {31'd0, valid_d2}, 32'd1);

    // RAW dependency: add x3,x1,x1 waits one cycle behind addi x1.
    feed(1'b1, 32'h00100093, 32'h200, 1'b1, 32'h001081B3, 32'h204, 1'b0);
    step_cycle();
    checkOutput("raw_first_ValidD2", {31'd0, valid_d2}, 32'd0);
    step_cycle();
    checkOutput("raw_second_InstrD1", instr_d1, 32'h001081B3);
    checkOutput("raw_second_ValidD2", {31'd0, valid_d2}, 32'd0);

    // Two memory operations share one data port.
    feed(1'b1, 32'h00002283, 32'h300, 1'b1, 32'h00602223, 32'h304, 1'b0);
    step_cycle();
    checkOutput("mem_first_InstrD1", instr_d1, 32'h00002283);
    checkOutput("mem_first_ValidD2", {31'd0, valid_d2}, 32'd0);
    step_cycle();
    checkOutput("mem_second_InstrD1", instr_d1, 32'h00602223);
    drain(2);

    // Fill to 7 under stall (last entry via lone F2), hold a pair, release.
    fill_addi(3, 32'h400, 1'b1);
    feed(1'b0, 32'hDEADBEEF, 32'h4F0, 1'b1, mk_addi(5'd20, 12'd7), 32'h418, 1'b1);
    checkOutput("ReadyF_at_7", {31'd0, ready_f}, 32'd0);
    applyStimulus(1'b1, mk_addi(5'd21, 12'd8), 32'h41C, 1'b1, mk_addi(5'd22, 12'd9), 32'h420, 1'b1, 1'b0);
    step_cycle();
    step_cycle();
    feed(1'b1, mk_addi(5'd21, 12'd8), 32'h41C, 1'b1, mk_addi(5'd22, 12'd9), 32'h420, 1'b0);
    drain(8);
    checkOutput("drainA_empty", {31'd0, valid_d1}, 32'd0);

    // Fill to 8 under stall, hold a pair, release and drain across the wrap.
    fill_addi(4, 32'h500, 1'b1);
    checkOutput("ReadyF_at_8", {31'd0, ready_f}, 32'd0);
    applyStimulus(1'b1, mk_addi(5'd23, 12'd10), 32'h520, 1'b1, mk_addi(5'd24, 12'd11), 32'h524, 1'b1, 1'b0);
    step_cycle();
    step_cycle();
    feed(1'b1, mk_addi(5'd23, 12'd10), 32'h520, 1'b1, mk_addi(5'd24, 12'd11), 32'h524, 1'b0);
    drain(8);
    checkOutput("drainB_empty", {31'd0, valid_d1}, 32'd0);

    // Flush with 5 queued under stall; same-cycle fetch slots are dropped.
    fill_addi(1, 32'h600, 1'b0);
    drain(1);
    fill_addi(2, 32'h610, 1'b1);
    feed(1'b1, mk_addi(5'd9, 12'd5), 32'h620, 1'b0, 32'd0, 32'd0, 1'b1);
    applyStimulus(1'b1, mk_addi(5'd10, 12'd6), 32'h624, 1'b1, mk_addi(5'd11, 12'd7), 32'h628, 1'b1, 1'b1);
    step_cycle();
    checkOutput("flush_ValidD1", {31'd0, valid_d1}, 32'd0);
    checkOutput("flush_ValidD2", {31'd0, valid_d2}, 32'd0);
    checkOutput("flush_ReadyF", {31'd0, ready_f}, 32'd1);
    drain(3);
    fill_addi(1, 32'h700, 1'b0);
    drain(2);

    // Asynchronous reset pulsed between edges with a group in the slots.
    fill_addi(2, 32'h800, 1'b0);
    drain(1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_ValidD1", {31'd0, valid_d1}, 32'd0);
    checkOutput("arst_ValidD2", {31'd0, valid_d2}, 32'd0);
    checkOutput("arst_InstrD1", instr_d1, NOP_I);
    checkOutput("arst_PCD2", pc_d2, 32'd0);
    checkOutput("arst_ReadyF", {31'd0, ready_f}, 32'd1);
    mq.delete();
    clear_expected();
    #1;
    rst = 1'b0;
    drain(2);
    fill_addi(1, 32'h900, 1'b0);
    drain(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
